// File: rtl/pll_reconfig_ctrl_if.sv
// ---------------------------------------------------------------------------
// pll_reconfig_ctrl_if
// Divider-change request channel for pll_reconfig_ctrl.
//   cfg_valid  : requester has a new IDSEL/FBDSEL pair
//   cfg_idsel  : requested IDSEL (PLL pin encoding)
//   cfg_fbdsel : requested FBDSEL (PLL pin encoding)
//   cfg_ready  : controller can accept a request this cycle
// master = requester, slave = controller.
// ---------------------------------------------------------------------------
interface pll_reconfig_ctrl_if;
  logic       cfg_valid;
  logic [5:0] cfg_idsel;
  logic [5:0] cfg_fbdsel;
  logic       cfg_ready;

  modport master (output cfg_valid, output cfg_idsel, output cfg_fbdsel,
                  input  cfg_ready);
  modport slave  (input  cfg_valid, input  cfg_idsel, input  cfg_fbdsel,
                  output cfg_ready);
endinterface

// File: rtl/pll_reconfig_ctrl.sv
// ---------------------------------------------------------------------------
// pll_reconfig_ctrl
// Sequencer for a Gowin PLLVR with dynamic IDIV/FBDIV. Runs on the PLL
// reference clock, drives IDSEL/FBDSEL/RESET/VREN, supervises LOCK and
// gates the downstream clock enable until the PLL is stably locked.
//
// Ports:
//   clk, rst_n        : reference clock, async active-low reset
//   cfg (slave)       : valid/ready divider-change request channel
//   pwrdn_req         : power-down request (only with PLL_PWRDN_EN)
//   pll_lock          : PLL LOCK (asynchronous, synchronized here)
//   pll_reset/vren    : to PLL RESET / VREN
//   pll_idsel/fbdsel  : to PLL IDSEL / FBDSEL
//   clk_en            : downstream enable, high only when locked and settled
//   busy              : a (re)lock sequence is in progress
//   error             : sticky lock failure, cleared by a new request
//
// Optional feature macro: PLL_PWRDN_EN (adds pwrdn_req and the PWRDN state).
// ---------------------------------------------------------------------------
module pll_reconfig_ctrl #(
  parameter logic [5:0] INIT_IDSEL    = 6'd0,
  parameter logic [5:0] INIT_FBDSEL   = 6'd0,
  parameter int         GATE_CYCLES   = 4,
  parameter int         RESET_CYCLES  = 16,
  parameter int         LOCK_TIMEOUT  = 4096,
  parameter int         SETTLE_CYCLES = 256,
  parameter int         MAX_RETRY     = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  pll_reconfig_ctrl_if.slave cfg,
`ifdef PLL_PWRDN_EN
  input  logic               pwrdn_req,
`endif
  input  logic               pll_lock,
  output logic               pll_reset,
  output logic               pll_vren,
  output logic [5:0]         pll_idsel,
  output logic [5:0]         pll_fbdsel,
  output logic               clk_en,
  output logic               busy,
  output logic               error
);

  localparam int MAX_GR  = (GATE_CYCLES > RESET_CYCLES) ? GATE_CYCLES : RESET_CYCLES;
  localparam int MAX_TS  = (LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES;
  localparam int MAX_P   = (MAX_GR > MAX_TS) ? MAX_GR : MAX_TS;
  localparam int CNT_W   = $clog2(MAX_P) + 1;
  localparam int RTRY_W  = $clog2(MAX_RETRY) + 1;

  localparam logic [CNT_W-1:0]  GATE_LAST   = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  RESET_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [RTRY_W-1:0] RETRY_LAST  = RTRY_W'(MAX_RETRY - 1);

  typedef enum logic [2:0] {
    S_RESET_HOLD, S_GATE, S_APPLY, S_WAIT_LOCK, S_SETTLE, S_IDLE_RUN, S_ERROR
`ifdef PLL_PWRDN_EN
    , S_PWRDN
`endif
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   tmo_q, tmo_d;
  logic [RTRY_W-1:0]  retry_q, retry_d;
  logic [5:0]         pend_idsel_q, pend_idsel_d, pend_fbdsel_q, pend_fbdsel_d;
  logic [5:0]         idsel_q, idsel_d, fbdsel_q, fbdsel_d;
  logic               lock_meta_q, lock_s_q, lock_lo_q, lock_lo_d;
  logic               pll_reset_q, pll_reset_d, clk_en_q, clk_en_d;
  logic               busy_q, busy_d, error_q, error_d, cfg_ready_q, cfg_ready_d;
  logic               accept;
`ifdef PLL_PWRDN_EN
  logic               pwr_pend_q, pwr_pend_d, vren_q, vren_d;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tmo_d         = tmo_q;
    retry_d       = retry_q;
    pend_idsel_d  = pend_idsel_q;
    pend_fbdsel_d = pend_fbdsel_q;
    idsel_d       = idsel_q;
    fbdsel_d      = fbdsel_q;
    lock_lo_d     = ~lock_s_q;
`ifdef PLL_PWRDN_EN
    pwr_pend_d    = pwr_pend_q;
`endif
    accept        = cfg.cfg_valid & cfg_ready_q;

    case (state_q)
      S_IDLE_RUN: begin
        // A request accepted in the same cycle as a lock loss takes priority;
        // the relock then happens with the new dividers.
        if (accept) begin
          pend_idsel_d  = cfg.cfg_idsel;
          pend_fbdsel_d = cfg.cfg_fbdsel;
          retry_d       = '0;
          cnt_d         = '0;
          state_d       = S_GATE;
        end
`ifdef PLL_PWRDN_EN
        else if (pwrdn_req) begin
          pwr_pend_d = 1'b1;
          cnt_d      = '0;
          state_d    = S_GATE;
        end
`endif
        else if (!lock_s_q && lock_lo_q) begin
          retry_d = '0;
          cnt_d   = '0;
          state_d = S_GATE;
        end
      end
      S_GATE: begin
        if (cnt_q >= GATE_LAST) begin
          cnt_d   = '0;
          state_d = S_APPLY;
`ifdef PLL_PWRDN_EN
          if (pwr_pend_q) state_d = S_PWRDN;
`endif
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      S_APPLY: begin
        // Reset already rose on entry, so the divider pins change under reset.
        // The APPLY cycle counts as the first reset cycle.
        idsel_d  = pend_idsel_q;
        fbdsel_d = pend_fbdsel_q;
        cnt_d    = CNT_W'(1);
        state_d  = S_RESET_HOLD;
      end
      S_RESET_HOLD: begin
        if (cnt_q >= RESET_LAST) begin
          cnt_d   = '0;
          tmo_d   = '0;
          state_d = S_WAIT_LOCK;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      S_WAIT_LOCK: begin
        if (lock_s_q) begin
          // The detecting sample is the first of the settle window.
          cnt_d   = CNT_W'(1);
          tmo_d   = sat_inc(tmo_q);
          state_d = S_SETTLE;
        end else if (tmo_q >= TMO_LAST) begin
          if (retry_q < RETRY_LAST) begin
            retry_d = retry_q + 1'b1;
            state_d = S_APPLY;
          end else begin
            state_d = S_ERROR;
          end
        end else begin
          tmo_d = sat_inc(tmo_q);
        end
      end
      S_SETTLE: begin
        // Timeout keeps running across settle so lock flapping still fails.
        tmo_d = sat_inc(tmo_q);
        if (!lock_s_q) begin
          cnt_d   = '0;
          state_d = S_WAIT_LOCK;
        end else if (cnt_q >= SETTLE_LAST) begin
          cnt_d   = '0;
          retry_d = '0;
          state_d = S_IDLE_RUN;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      S_ERROR: begin
        if (accept) begin
          pend_idsel_d  = cfg.cfg_idsel;
          pend_fbdsel_d = cfg.cfg_fbdsel;
          retry_d       = '0;
          state_d       = S_APPLY;
        end
`ifdef PLL_PWRDN_EN
        else if (pwrdn_req) begin
          pwr_pend_d = 1'b1;
          cnt_d      = '0;
          state_d    = S_GATE;
        end
`endif
      end
`ifdef PLL_PWRDN_EN
      S_PWRDN: begin
        if (!pwrdn_req) begin
          pwr_pend_d = 1'b0;
          cnt_d      = '0;
          state_d    = S_RESET_HOLD;
        end
      end
`endif
      default: state_d = S_RESET_HOLD;
    endcase

    // Outputs are registered and decoded from the next state.
    pll_reset_d = pll_reset_q;
    clk_en_d    = 1'b0;
    busy_d      = 1'b1;
    cfg_ready_d = 1'b0;
    case (state_d)
      S_IDLE_RUN:              begin pll_reset_d = 1'b0; clk_en_d = 1'b1; busy_d = 1'b0; cfg_ready_d = 1'b1; end
      S_APPLY, S_RESET_HOLD:   pll_reset_d = 1'b1;
      S_WAIT_LOCK, S_SETTLE:   pll_reset_d = 1'b0;
      S_ERROR:                 begin pll_reset_d = 1'b1; busy_d = 1'b0; cfg_ready_d = 1'b1; end
`ifdef PLL_PWRDN_EN
      S_PWRDN:                 begin pll_reset_d = 1'b1; busy_d = 1'b0; end
`endif
      default:                 ;
    endcase

    error_d = error_q;
    if (state_d == S_ERROR)                    error_d = 1'b1;
    else if (state_d == S_IDLE_RUN || accept)  error_d = 1'b0;

`ifdef PLL_PWRDN_EN
    vren_d = (state_d != S_PWRDN);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_RESET_HOLD;
      cnt_q         <= '0;
      tmo_q         <= '0;
      retry_q       <= '0;
      pend_idsel_q  <= INIT_IDSEL;
      pend_fbdsel_q <= INIT_FBDSEL;
      idsel_q       <= INIT_IDSEL;
      fbdsel_q      <= INIT_FBDSEL;
      lock_meta_q   <= 1'b0;
      lock_s_q      <= 1'b0;
      lock_lo_q     <= 1'b0;
      pll_reset_q   <= 1'b1;
      clk_en_q      <= 1'b0;
      busy_q        <= 1'b1;
      error_q       <= 1'b0;
      cfg_ready_q   <= 1'b0;
`ifdef PLL_PWRDN_EN
      pwr_pend_q    <= 1'b0;
      vren_q        <= 1'b1;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      retry_q       <= retry_d;
      pend_idsel_q  <= pend_idsel_d;
      pend_fbdsel_q <= pend_fbdsel_d;
      idsel_q       <= idsel_d;
      fbdsel_q      <= fbdsel_d;
      lock_meta_q   <= pll_lock;
      lock_s_q      <= lock_meta_q;
      lock_lo_q     <= lock_lo_d;
      pll_reset_q   <= pll_reset_d;
      clk_en_q      <= clk_en_d;
      busy_q        <= busy_d;
      error_q       <= error_d;
      cfg_ready_q   <= cfg_ready_d;
`ifdef PLL_PWRDN_EN
      pwr_pend_q    <= pwr_pend_d;
      vren_q        <= vren_d;
`endif
    end
  end

  assign cfg.cfg_ready = cfg_ready_q;
  assign pll_reset     = pll_reset_q;
  assign pll_idsel     = idsel_q;
  assign pll_fbdsel    = fbdsel_q;
  assign clk_en        = clk_en_q;
  assign busy          = busy_q;
  assign error         = error_q;
`ifdef PLL_PWRDN_EN
  assign pll_vren      = vren_q;
`else
  assign pll_vren      = 1'b1;
`endif

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pll_reconfig_ctrl
// Directed bench for pll_reconfig_ctrl with GATE=2, RESET=4, TIMEOUT=16,
// SETTLE=8, MAX_RETRY=2, INIT dividers 62/58. A cycle-stepped vector table
// covers power-up, reconfiguration, lock glitch, relock, error and reset;
// hand-written sequences cover cfg-vs-lock-loss, ignored requests and
// (with PLL_PWRDN_EN) power-down.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pll_reconfig_ctrl;

  localparam logic [5:0] I_ID = 6'd62, I_FB = 6'd58;
  localparam logic [5:0] N_ID = 6'd61, N_FB = 6'd55;
  localparam logic [5:0] M_ID = 6'd40, M_FB = 6'd20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       pll_reset, pll_vren, clk_en, busy, error;
  logic [5:0] pll_idsel, pll_fbdsel;
`ifdef PLL_PWRDN_EN
  logic       pwrdn_req = 1'b0;
`endif

  pll_reconfig_ctrl_if cfg_if ();

  pll_reconfig_ctrl #(
    .INIT_IDSEL(I_ID), .INIT_FBDSEL(I_FB), .GATE_CYCLES(2), .RESET_CYCLES(4),
    .LOCK_TIMEOUT(16), .SETTLE_CYCLES(8), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg(cfg_if),
`ifdef PLL_PWRDN_EN
    .pwrdn_req(pwrdn_req),
`endif
    .pll_lock(pll_lock), .pll_reset(pll_reset), .pll_vren(pll_vren),
    .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel), .clk_en(clk_en),
    .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       rst_n;
    logic       lock;
    logic       valid;
    logic [5:0] ci, cf;
    int         n;
    logic [17:0] exp;   // {reset, clk_en, busy, ready, error, vren, idsel, fbdsel}
  } vec_t;

  function automatic vec_t v(input logic r, input logic l, input logic va,
                             input logic [5:0] ci, input logic [5:0] cf, input int n,
                             input logic er, input logic ec, input logic eb,
                             input logic ey, input logic ee,
                             input logic [5:0] ei, input logic [5:0] ef);
    vec_t t;
    t.rst_n = r; t.lock = l; t.valid = va; t.ci = ci; t.cf = cf; t.n = n;
    t.exp = {er, ec, eb, ey, ee, 1'b1, ei, ef};
    return t;
  endfunction

  function automatic logic [17:0] outs();
    return {pll_reset, clk_en, busy, cfg_if.cfg_ready, error, pll_vren, pll_idsel, pll_fbdsel};
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Divider pins may only move while the PLL is held in reset.
  logic [11:0] prev_div = 12'd0;
  always @(negedge clk) begin
    if ({pll_idsel, pll_fbdsel} != prev_div)
      chk("div_change_under_reset", {31'd0, pll_reset}, 32'd1);
    prev_div = {pll_idsel, pll_fbdsel};
  end

  vec_t tbl[$];

  initial begin
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_idsel  = 6'd0;
    cfg_if.cfg_fbdsel = 6'd0;

    // power-up: lock 3 cycles after reset falls, clk_en 2+8 cycles after lock
    tbl.push_back(v(0,0,0,0,0, 0, 1,0,1,0,0, I_ID,I_FB));
    tbl.push_back(v(1,0,0,0,0, 3, 1,0,1,0,0, I_ID,I_FB));
    tbl.push_back(v(1,0,0,0,0, 1, 0,0,1,0,0, I_ID,I_FB));
    tbl.push_back(v(1,0,0,0,0, 3, 0,0,1,0,0, I_ID,I_FB));
    tbl.push_back(v(1,1,0,0,0, 9, 0,0,1,0,0, I_ID,I_FB));
    tbl.push_back(v(1,1,0,0,0, 1, 0,1,0,1,0, I_ID,I_FB));
    // cfg 61/55 in run
    tbl.push_back(v(1,1,1,N_ID,N_FB, 1, 0,0,1,0,0, I_ID,I_FB));
    tbl.push_back(v(1,1,0,0,0, 1, 0,0,1,0,0, I_ID,I_FB));
    tbl.push_back(v(1,1,0,0,0, 1, 1,0,1,0,0, I_ID,I_FB));
    tbl.push_back(v(1,0,0,0,0, 1, 1,0,1,0,0, N_ID,N_FB));
    tbl.push_back(v(1,0,0,0,0, 2, 1,0,1,0,0, N_ID,N_FB));
    tbl.push_back(v(1,0,0,0,0, 1, 0,0,1,0,0, N_ID,N_FB));
    tbl.push_back(v(1,0,0,0,0, 3, 0,0,1,0,0, N_ID,N_FB));
    tbl.push_back(v(1,1,0,0,0, 9, 0,0,1,0,0, N_ID,N_FB));
    tbl.push_back(v(1,1,0,0,0, 1, 0,1,0,1,0, N_ID,N_FB));
    // 2-cycle lock drop in run -> relock; 1-cycle glitch at settle count 5
    tbl.push_back(v(1,0,0,0,0, 2, 0,1,0,1,0, N_ID,N_FB));
    tbl.push_back(v(1,1,0,0,0, 1, 0,1,0,1,0, N_ID,N_FB));
    tbl.push_back(v(1,1,0,0,0, 1, 0,0,1,0,0, N_ID,N_FB));
    tbl.push_back(v(1,1,0,0,0, 2, 1,0,1,0,0, N_ID,N_FB));
    tbl.push_back(v(1,1,0,0,0, 4, 0,0,1,0,0, N_ID,N_FB));
    tbl.push_back(v(1,1,0,0,0, 3, 0,0,1,0,0, N_ID,N_FB));
    tbl.push_back(v(1,0,0,0,0, 1, 0,0,1,0,0, N_ID,N_FB));
    tbl.push_back(v(1,1,0,0,0, 9, 0,0,1,0,0, N_ID,N_FB));
    tbl.push_back(v(1,1,0,0,0, 1, 0,1,0,1,0, N_ID,N_FB));
    // lock held low: two resets with 16-cycle waits, then error
    tbl.push_back(v(1,0,0,0,0, 4, 0,0,1,0,0, N_ID,N_FB));
    tbl.push_back(v(1,0,0,0,0, 2, 1,0,1,0,0, N_ID,N_FB));
    tbl.push_back(v(1,0,0,0,0, 4, 0,0,1,0,0, N_ID,N_FB));
    tbl.push_back(v(1,0,0,0,0,15, 0,0,1,0,0, N_ID,N_FB));
    tbl.push_back(v(1,0,0,0,0, 1, 1,0,1,0,0, N_ID,N_FB));
    tbl.push_back(v(1,0,0,0,0, 4, 0,0,1,0,0, N_ID,N_FB));
    tbl.push_back(v(1,0,0,0,0,15, 0,0,1,0,0, N_ID,N_FB));
    tbl.push_back(v(1,0,0,0,0, 1, 1,0,0,1,1, N_ID,N_FB));
    tbl.push_back(v(1,0,0,0,0, 3, 1,0,0,1,1, N_ID,N_FB));
    // new cfg clears error
    tbl.push_back(v(1,0,1,M_ID,M_FB, 1, 1,0,1,0,0, N_ID,N_FB));
    tbl.push_back(v(1,0,0,0,0, 1, 1,0,1,0,0, M_ID,M_FB));
    tbl.push_back(v(1,0,0,0,0, 4, 0,0,1,0,0, M_ID,M_FB));
    // rst_n pulsed during WAIT_LOCK: async reset, dividers back to INIT
    tbl.push_back(v(0,0,0,0,0, 0, 1,0,1,0,0, I_ID,I_FB));
    tbl.push_back(v(1,0,0,0,0, 3, 1,0,1,0,0, I_ID,I_FB));
    tbl.push_back(v(1,0,0,0,0, 1, 0,0,1,0,0, I_ID,I_FB));

    tick(2);
    foreach (tbl[k]) begin
      rst_n             = tbl[k].rst_n;
      pll_lock          = tbl[k].lock;
      cfg_if.cfg_valid  = tbl[k].valid;
      cfg_if.cfg_idsel  = tbl[k].ci;
      cfg_if.cfg_fbdsel = tbl[k].cf;
      if (tbl[k].n == 0) #1;
      else tick(tbl[k].n);
      chk($sformatf("row%0d", k), {14'd0, outs()}, {14'd0, tbl[k].exp});
    end

    // Relock to run, then cfg accept coincides with lock-loss detection.
    pll_lock = 1'b1;
    for (int i = 0; i < 40 && !clk_en; i++) tick(1);
    chk("relock_before_race", {31'd0, clk_en}, 32'd1);
    pll_lock = 1'b0;
    tick(3);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_idsel  = 6'd33;
    cfg_if.cfg_fbdsel = 6'd44;
    tick(1);
    chk("race_gate", {30'd0, clk_en, cfg_if.cfg_ready}, 32'd0);
    // While busy a request with other data must be ignored.
    cfg_if.cfg_idsel  = 6'd1;
    cfg_if.cfg_fbdsel = 6'd2;
    tick(1);
    cfg_if.cfg_valid = 1'b0;
    pll_lock = 1'b1;
    for (int i = 0; i < 60 && !clk_en; i++) tick(1);
    chk("race_relock", {31'd0, clk_en}, 32'd1);
    chk("cfg_wins_div", {20'd0, pll_idsel, pll_fbdsel}, {20'd0, 6'd33, 6'd44});

`ifdef PLL_PWRDN_EN
    pwrdn_req = 1'b1;
    tick(2);
    chk("pwrdn_gate", {30'd0, pll_vren, clk_en}, 32'd2);
    tick(1);
    chk("pwrdn_state", {28'd0, pll_vren, pll_reset, busy, cfg_if.cfg_ready}, 32'b0100);
    pwrdn_req = 1'b0;
    tick(1);
    chk("pwrdn_release", {30'd0, pll_vren, pll_reset}, 32'd3);
    for (int i = 0; i < 60 && !clk_en; i++) tick(1);
    chk("pwrdn_relock", {31'd0, clk_en}, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pll_reconfig_ctrl.md
Name: pll_reconfig_ctrl

Overview:
- Sequences a Gowin PLLVR used with dynamic dividers (DYN_IDIV_SEL/DYN_FBDIV_SEL = "true").
- Runs on the PLL reference clock and drives the PLL's IDSEL, FBDSEL, RESET and VREN inputs.
- Supervises lock, and gates the downstream clock-enable so user logic on CLKOUT only runs once the PLL is stably locked.
- Accepts runtime divider changes through a valid/ready handshake, with timeout and retry on lock failure.

Parameters:
- INIT_IDSEL, 6'd0, IDSEL value applied after reset (PLL pin encoding: inverted divider).
- INIT_FBDSEL, 6'd0, FBDSEL value applied after reset.
- GATE_CYCLES, 4, clk cycles clk_en is held low before the PLL is reset.
- RESET_CYCLES, 16, clk cycles pll_reset is held high.
- LOCK_TIMEOUT, 4096, max clk cycles to wait for lock after reset release.
- SETTLE_CYCLES, 256, consecutive locked cycles required before run.
- MAX_RETRY, 3, reset attempts per configuration before error.

Ports:
- clk in 1: PLL reference clock.
- rst_n in 1: async active-low reset.
- cfg_valid in 1: new divider request.
- cfg_idsel in 6: requested IDSEL.
- cfg_fbdsel in 6: requested FBDSEL.
- cfg_ready out 1: request can be accepted.
- pll_lock in 1: PLL LOCK, asynchronous.
- pll_reset out 1: to PLL RESET.
- pll_vren out 1: to PLL VREN.
- pll_idsel out 6: to PLL IDSEL.
- pll_fbdsel out 6: to PLL FBDSEL.
- clk_en out 1: downstream enable, high only when locked and settled.
- busy out 1: sequence in progress.
- error out 1: sticky lock failure.

Behaviour:
- Reset state (rst_n low):
  - pll_reset=1, pll_vren=1, clk_en=0, busy=1, error=0, cfg_ready=0.
  - pll_idsel=INIT_IDSEL, pll_fbdsel=INIT_FBDSEL.
  - Retry counter=0; state=RESET_HOLD.
- pll_lock passes through a 2-FF synchronizer (lock_s) before use, adding 2 cycles of latency.
- States:
  - IDLE_RUN: clk_en=1, busy=0, cfg_ready=1.
    - cfg_valid&cfg_ready captures cfg_idsel/cfg_fbdsel into pending registers and goes to GATE.
    - lock_s low for 2 consecutive cycles: clk_en drops on the next cycle, retry counter=0, go to GATE (relock with the current dividers).
  - GATE: clk_en=0, busy=1, cfg_ready=0; hold GATE_CYCLES, then go to APPLY.
  - APPLY (1 cycle): load pending values into pll_idsel/pll_fbdsel, assert pll_reset, go to RESET_HOLD. Dividers change only while pll_reset is high.
  - RESET_HOLD: pll_reset=1 for RESET_CYCLES cycles, then deassert and go to WAIT_LOCK.
  - WAIT_LOCK: count up to LOCK_TIMEOUT.
    - lock_s=1: go to SETTLE.
    - Timeout with retry<MAX_RETRY-1: retry++, go to APPLY.
    - Timeout otherwise: go to ERROR.
  - SETTLE: count consecutive lock_s=1 cycles.
    - Any lock_s=0 clears the count and returns to WAIT_LOCK; the timeout counter continues and is not restarted.
    - Count reaching SETTLE_CYCLES: retry=0, go to IDLE_RUN.
  - ERROR: error=1, clk_en=0, busy=0, cfg_ready=1, pll_reset=1 held.
    - An accepted cfg clears error and goes to APPLY (no GATE needed).
- Counters are sized with $clog2 of the largest parameter plus 1, saturate, and never wrap.
- Handshake:
  - cfg_ready is a registered function of state only.
  - cfg_valid with cfg_ready=0 is ignored, not queued; the requester holds valid.
- Simultaneous cfg accept and lock loss in IDLE_RUN: the cfg wins and the new dividers are applied.
- rst_n asserted mid-sequence: immediate return to the reset state. Pending cfg is discarded and dividers revert to INIT.
- pll_vren is constant 1 unless the feature below is enabled.

Optional Feature:
- PLL_PWRDN_EN: adds input pwrdn_req (1 bit).
  - In IDLE_RUN or ERROR, pwrdn_req=1 goes via GATE to state PWRDN: pll_vren=0, pll_reset=1, clk_en=0, busy=0, cfg_ready=0.
  - pwrdn_req=0 then goes to RESET_HOLD with pll_vren=1 on the same cycle, then follows the normal sequence.
- Without the macro: no port, no PWRDN state, pll_vren tied 1.

Test Plan:
All scenarios use GATE=2, RESET=4, TIMEOUT=16, SETTLE=8, MAX_RETRY=2.
- Power-up with pll_lock rising 3 cycles after pll_reset falls -> pll_reset high 4 cycles after rst_n release, clk_en rises exactly 2+8 cycles after lock rises (2 sync + 8 settle), busy falls with it.
- cfg idsel=6'd61, fbdsel=6'd55 accepted in run -> clk_en low the next cycle, pll_idsel changes only while pll_reset=1, clk_en returns after lock+settle, cfg_ready low throughout.
- pll_lock held 0 -> two 4-cycle resets with 16-cycle waits, then error=1, cfg_ready=1; a new cfg clears error within 1 cycle.
- Lock glitch low for 1 cycle during SETTLE at count 5 -> count restarts, clk_en delayed by 6 extra cycles. 2-cycle drop in run -> relock sequence, dividers unchanged.
- rst_n pulsed low during WAIT_LOCK after a cfg change -> dividers return to INIT values, pll_reset=1 asynchronously.
- PLL_PWRDN_EN built, pwrdn_req=1 in run -> after 2 gate cycles pll_vren=0. Release -> pll_vren=1, full relock to clk_en=1.
